d_jump_ras: RTL and testbench
=============================

// Module: d_jump_ras
// PURPOSE
//  D-stage jump resolver for the MIPS pipeline: decodes j/jal/jr/jalr, outputs jump target + taken flag.
//  Adds a parametrised return-address stack (RAS) predicting jr $ra targets, pushed by jal/jalr.
//  Checks each prediction against the forwarded rs value and flags mispredicts; stalls D on an unready jr.
//  Sits beside the D-stage decoder/forwarding mux; JumpNPC/JumpJudge feed F-stage NPC select.
// PARAMETERS
//  RAS_DEPTH  8   entries in return-address stack; power of 2, >=2
//  PTR_W      3   log2(RAS_DEPTH); stack pointer width
//  RA_REG     31  GPR index treated as return-address register for push/pop
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   synchronous, active-high
//  en            in   1   D-stage advancing this cycle (not stalled); gates all state updates
//  flush         in   1   instruction in D is cancelled; no state update, outputs forced inactive
//  PC            in   32  PC of instruction in D
//  instr         in   32  instruction in D
//  D1            in   32  forwarded rs value
//  D1_ready      in   1   D1 holds final rs value (no pending hazard)
//  JumpNPC       out  32  jump target; 0 when JumpJudge=0
//  JumpJudge     out  1   jump taken this cycle
//  jump_stall    out  1   jr/jalr waiting on D1_ready
//  ras_top       out  32  current top-of-stack entry (0 when empty)
//  ras_pred_valid out 1   stack non-empty
//  ras_count     out  PTR_W+1  valid entries, 0..RAS_DEPTH
//  ras_mispred   out  1   registered 1-cycle pulse: last pop's prediction != D1
// BEHAVIOUR
//  Decode: j op=6'h02; jal op=6'h03; jr op=0,funct=6'h08; jalr op=0,funct=6'h09; rs=instr[25:21].
//  j/jal: JumpJudge=1, JumpNPC={PC[31:28],instr[25:0],2'b00}; independent of D1_ready.
//  jr/jalr, D1_ready=1: JumpJudge=1, JumpNPC=D1. D1_ready=0: JumpJudge=0, JumpNPC=0, jump_stall=1.
//  Other instr, or flush=1: JumpJudge=0, JumpNPC=0, jump_stall=0. Outputs purely combinational.
//  Commit = en & ~flush & (jump instr) & (j/jal or D1_ready). State changes only on commit.
//  Push (jal, jalr): write PC+8 at sp, sp<=sp+1 (mod RAS_DEPTH), count<=min(count+1,RAS_DEPTH).
//  Full push: overwrites oldest entry (circular wrap), count stays RAS_DEPTH.
//  Pop (jr or jalr with rs==RA_REG): if count>0: sp<=sp-1, count<=count-1,
//   ras_mispred<=(D1!=ras_top) next cycle. If count==0: no change, ras_mispred<=0.
//  jalr with rs==RA_REG: pop then push in same cycle; net count unchanged, top replaced by PC+8.
//  ras_mispred is 0 in every cycle not following a non-empty pop; never held.
//  jr with rs!=RA_REG: no stack action, no mispredict check.
//  en=0 or flush=1: stack, sp, count, stats hold; ras_mispred<=0.
//  ras_top = entry[sp-1] when count>0 else 0; ras_pred_valid = (count!=0).
//  Reset: sp=0, count=0, all entries=0, ras_mispred=0, stats counters=0; reset dominates en.
// CONFIGURATION
//  JUMP_RAS_STATS_EN defined: adds outputs stat_jumps[31:0] (commits taken) and stat_mispred[31:0]
//   (pulses of ras_mispred); both wrap at 2^32, cleared by reset, hold when en=0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  reset 1 cycle -> ras_count=0, ras_pred_valid=0, ras_top=0, ras_mispred=0, JumpJudge=0.
//  PC=0x0040_3000, jal 0x0100_0400 (instr=0x0C40_0100), en=1 -> JumpNPC=0x0100_0400, JumpJudge=1;
//   next cycle ras_top=0x0040_3008, ras_count=1.
//  then jr $31, D1=0x0040_3008, D1_ready=1 -> JumpNPC=0x0040_3008; ras_count=0, ras_mispred=0 next cycle.
//  jal, then jr $31 with D1=0x0040_4000 -> ras_mispred=1 for exactly one cycle; stat_mispred=1 if EN.
//  jr $31, D1_ready=0 -> jump_stall=1, JumpJudge=0, stack unchanged; D1_ready=1 next -> pop commits.
//  9 jals from PC=0x100,0x200..0x900 (depth 8) -> ras_count=8, ras_top=0x908; 8 pops return
//   0x908..0x208; 9th pop on empty -> count 0, ras_mispred=0; flush during jal -> no push.

Source files
------------

// File: rtl/d_jump_ras.sv
// D-stage jump resolver (j/jal/jr/jalr) with a circular return-address stack.
// Optional build macro JUMP_RAS_STATS_EN adds the stat_jumps/stat_mispred counters.
module d_jump_ras #(
   parameter int RAS_DEPTH = 8,
   parameter int PTR_W     = 3,
   parameter int RA_REG    = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic [31:0]       PC,
   input  logic [31:0]       instr,
   input  logic [31:0]       D1,
   input  logic              D1_ready,
   output logic [31:0]       JumpNPC,
   output logic              JumpJudge,
   output logic              jump_stall,
   output logic [31:0]       ras_top,
   output logic              ras_pred_valid,
   output logic [PTR_W:0]    ras_count,
   output logic              ras_mispred
`ifdef JUMP_RAS_STATS_EN
   ,
   output logic [31:0]       stat_jumps,
   output logic [31:0]       stat_mispred
`endif
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       rs;
   logic             is_j, is_jal, is_jr, is_jalr;
   logic             commit, do_push, do_pop;

   logic [31:0]      ras_q [RAS_DEPTH];
   logic [31:0]      ras_d [RAS_DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d, sp_pop, top_idx;
   logic [PTR_W:0]   cnt_q, cnt_d, cnt_pop;
   logic             mispred_q, mispred_d;

   logic             unused_instr_bits;
   assign unused_instr_bits = ^instr[20:6];

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign rs    = instr[25:21];

   always_comb begin
      is_j    = (op == 6'h02);
      is_jal  = (op == 6'h03);
      is_jr   = (op == 6'h00) && (funct == 6'h08);
      is_jalr = (op == 6'h00) && (funct == 6'h09);
   end

   always_comb begin
      JumpJudge  = 1'b0;
      JumpNPC    = '0;
      jump_stall = 1'b0;
      if (!flush) begin
         if (is_j || is_jal) begin
            JumpJudge = 1'b1;
            JumpNPC   = {PC[31:28], instr[25:0], 2'b00};
         end else if (is_jr || is_jalr) begin
            if (D1_ready) begin
               JumpJudge = 1'b1;
               JumpNPC   = D1;
            end else begin
               jump_stall = 1'b1;
            end
         end
      end
   end

   assign commit  = en && JumpJudge;
   assign do_push = commit && (is_jal || is_jalr);
   assign do_pop  = commit && (is_jr || is_jalr) && (rs == 5'(RA_REG));

   assign top_idx        = sp_q - PTR_W'(1);
   assign ras_top        = (cnt_q != '0) ? ras_q[top_idx] : '0;
   assign ras_pred_valid = (cnt_q != '0);
   assign ras_count      = cnt_q;
   assign ras_mispred    = mispred_q;

   // Pop is applied first, then push on the popped pointer: a jalr $ra
   // therefore overwrites the old top in place with its own return address.
   always_comb begin
      ras_d     = ras_q;
      sp_pop    = sp_q;
      cnt_pop   = cnt_q;
      mispred_d = 1'b0;
      if (do_pop && (cnt_q != '0)) begin
         sp_pop    = top_idx;
         cnt_pop   = cnt_q - (PTR_W+1)'(1);
         mispred_d = (D1 != ras_top);
      end
      sp_d  = sp_pop;
      cnt_d = cnt_pop;
      if (do_push) begin
         ras_d[sp_pop] = PC + 32'd8;
         sp_d          = sp_pop + PTR_W'(1);
         cnt_d         = (cnt_pop == FULL) ? FULL : cnt_pop + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
         sp_q      <= '0;
         cnt_q     <= '0;
         mispred_q <= 1'b0;
      end else begin
         ras_q     <= ras_d;
         sp_q      <= sp_d;
         cnt_q     <= cnt_d;
         mispred_q <= mispred_d;
      end
   end

`ifdef JUMP_RAS_STATS_EN
   logic [31:0] stat_jumps_q, stat_jumps_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   // Mispredicts are counted at the edge that raises the pulse.
   always_comb begin
      stat_jumps_d   = stat_jumps_q;
      stat_mispred_d = stat_mispred_q;
      if (commit)    stat_jumps_d   = stat_jumps_q + 32'd1;
      if (mispred_d) stat_mispred_d = stat_mispred_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_jumps_q   <= '0;
         stat_mispred_q <= '0;
      end else begin
         stat_jumps_q   <= stat_jumps_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   assign stat_jumps   = stat_jumps_q;
   assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_d_jump_ras.sv
// Directed bench for d_jump_ras: combinational jump outputs checked per step,
// stack state checked against a queue-based stack model via a scoreboard.
module tb_d_jump_ras;

   logic        clk = 1'b0;
   logic        reset, en, flush, D1_ready;
   logic [31:0] PC, instr, D1;
   logic [31:0] JumpNPC, ras_top;
   logic        JumpJudge, jump_stall, ras_pred_valid, ras_mispred;
   logic [3:0]  ras_count;
`ifdef JUMP_RAS_STATS_EN
   logic [31:0] stat_jumps, stat_mispred;
`endif

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  cnt;
      logic [31:0] top;
      logic        misp;
      logic [31:0] jumps;
      logic [31:0] misps;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model[$];
   logic [31:0] m_jumps = 0;
   logic [31:0] m_misps = 0;

   d_jump_ras #(.RAS_DEPTH(8), .PTR_W(3), .RA_REG(31)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .PC(PC), .instr(instr),
      .D1(D1), .D1_ready(D1_ready), .JumpNPC(JumpNPC), .JumpJudge(JumpJudge),
      .jump_stall(jump_stall), .ras_top(ras_top), .ras_pred_valid(ras_pred_valid),
      .ras_count(ras_count), .ras_mispred(ras_mispred)
`ifdef JUMP_RAS_STATS_EN
      , .stat_jumps(stat_jumps), .stat_mispred(stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] f_jal(input logic [31:0] tgt);
      return {6'h03, tgt[27:2]};
   endfunction
   function automatic logic [31:0] f_j(input logic [31:0] tgt);
      return {6'h02, tgt[27:2]};
   endfunction
   function automatic logic [31:0] f_jr(input logic [4:0] r);
      return {6'h00, r, 15'h0, 6'h08};
   endfunction
   function automatic logic [31:0] f_jalr(input logic [4:0] r);
      return {6'h00, r, 5'h00, 5'd31, 5'h00, 6'h09};
   endfunction

   task automatic step(input string tag, input logic [31:0] pc_i, input logic [31:0] instr_i,
                       input logic [31:0] d1_i, input logic rdy_i, input logic en_i,
                       input logic flush_i, input logic exp_judge, input logic [31:0] exp_npc,
                       input logic exp_stall);
      exp_t        e;
      logic [31:0] t;
      logic        misp, is_push, is_pop;
      @(negedge clk);
      PC = pc_i; instr = instr_i; D1 = d1_i; D1_ready = rdy_i; en = en_i; flush = flush_i;
      #1;
      chk({tag, ".judge"}, 32'(JumpJudge), 32'(exp_judge));
      chk({tag, ".npc"}, JumpNPC, exp_npc);
      chk({tag, ".stall"}, 32'(jump_stall), 32'(exp_stall));
      is_push = (instr_i[31:26] == 6'h03) ||
                (instr_i[31:26] == 6'h00 && instr_i[5:0] == 6'h09);
      is_pop  = (instr_i[31:26] == 6'h00) && (instr_i[5:0] == 6'h08 || instr_i[5:0] == 6'h09)
                && (instr_i[25:21] == 5'd31);
      misp = 1'b0;
      if (en_i && !flush_i && exp_judge) begin
         if (is_pop && model.size() > 0) begin
            t = model.pop_back();
            misp = (d1_i != t);
         end
         if (is_push) begin
            model.push_back(pc_i + 32'd8);
            if (model.size() > 8) t = model.pop_front();
         end
         m_jumps++;
         if (misp) m_misps++;
      end
      e.cnt   = 4'(model.size());
      e.top   = (model.size() > 0) ? model[$] : 32'h0;
      e.misp  = misp;
      e.jumps = m_jumps;
      e.misps = m_misps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".count"}, 32'(ras_count), 32'(e.cnt));
      chk({tag, ".top"}, ras_top, e.top);
      chk({tag, ".valid"}, 32'(ras_pred_valid), 32'(e.cnt != 0));
      chk({tag, ".mispred"}, 32'(ras_mispred), 32'(e.misp));
`ifdef JUMP_RAS_STATS_EN
      chk({tag, ".stat_jumps"}, stat_jumps, e.jumps);
      chk({tag, ".stat_mispred"}, stat_mispred, e.misps);
`endif
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0; PC = '0; instr = '0; D1 = '0; D1_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst.count", 32'(ras_count), 32'h0);
      chk("rst.valid", 32'(ras_pred_valid), 32'h0);
      chk("rst.top", ras_top, 32'h0);
      chk("rst.mispred", 32'(ras_mispred), 32'h0);
      chk("rst.judge", 32'(JumpJudge), 32'h0);

      // jal / matching jr
      step("jal1", 32'h0040_3000, 32'h0C40_0100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0100_0400, 1'b0);
      chk("jal1.top_const", ras_top, 32'h0040_3008);
      step("jr1", 32'h0100_0400, f_jr(5'd31), 32'h0040_3008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_3008, 1'b0);

      // mispredicted return: one-cycle pulse
      step("jal2", 32'h0040_3000, 32'h0C40_0100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0100_0400, 1'b0);
      step("jr_bad", 32'h0100_0400, f_jr(5'd31), 32'h0040_4000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_4000, 1'b0);
      chk("jr_bad.pulse", 32'(ras_mispred), 32'h1);
      step("nop1", 32'h0040_4000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // unready jr stalls, then commits
      step("jal3", 32'h0040_3000, 32'h0C40_0100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0100_0400, 1'b0);
      step("jr_wait", 32'h0100_0400, f_jr(5'd31), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step("jr_go", 32'h0100_0400, f_jr(5'd31), 32'h0040_3008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_3008, 1'b0);

      // overflow: 9 pushes into depth 8
      for (int i = 1; i <= 9; i++)
         step("fill", 32'(i * 32'h100), f_jal(32'h0040_0000 + 32'(i * 16)), 32'h0, 1'b0, 1'b1, 1'b0,
              1'b1, 32'h0040_0000 + 32'(i * 16), 1'b0);
      chk("fill.count_const", 32'(ras_count), 32'h8);
      chk("fill.top_const", ras_top, 32'h0000_0908);
      for (int k = 9; k >= 2; k--)
         step("drain", 32'h0000_5000, f_jr(5'd31), 32'(k * 32'h100 + 8), 1'b1, 1'b1, 1'b0,
              1'b1, 32'(k * 32'h100 + 8), 1'b0);
      step("pop_empty", 32'h0000_5000, f_jr(5'd31), 32'h0000_0108, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0108, 1'b0);
      chk("pop_empty.count_const", 32'(ras_count), 32'h0);

      // flush and stall-free hold
      step("flush_jal", 32'h0000_0700, f_jal(32'h0000_0800), 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step("en0_jal", 32'h0000_0700, f_jal(32'h0000_0800), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0);

      // jalr $ra replaces top; jr non-ra and j leave stack alone
      step("jal4", 32'h0000_0500, f_jal(32'h0000_0A00), 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0A00, 1'b0);
      step("jalr_ok", 32'h0000_0600, f_jalr(5'd31), 32'h0000_0508, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0508, 1'b0);
      chk("jalr_ok.top_const", ras_top, 32'h0000_0608);
      step("jalr_bad", 32'h0000_0700, f_jalr(5'd31), 32'h0000_0123, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0123, 1'b0);
      step("jr_r5", 32'h0000_0800, f_jr(5'd5), 32'h0000_0444, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0444, 1'b0);
      step("j", 32'h3000_0800, f_j(32'h0000_0C00), 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3000_0C00, 1'b0);
      step("nop2", 32'h0000_0900, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // reset dominates an enabled jal
      @(negedge clk);
      reset = 1'b1; en = 1'b1; flush = 1'b0; PC = 32'h0000_0100; instr = f_jal(32'h0000_0200);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst2.count", 32'(ras_count), 32'h0);
      chk("rst2.top", ras_top, 32'h0);
      chk("rst2.mispred", 32'(ras_mispred), 32'h0);
`ifdef JUMP_RAS_STATS_EN
      chk("rst2.stat_jumps", stat_jumps, 32'h0);
      chk("rst2.stat_mispred", stat_mispred, 32'h0);
`endif
      model.delete();
      m_jumps = 0;
      m_misps = 0;
      step("jal5", 32'h0040_3000, 32'h0C40_0100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0100_0400, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
